stream_scheduler: RTL

STREAM_SCHEDULER -- requirements
Module: stream_scheduler

---
 rtl/bad_apple_pkg.sv | 19 +
 rtl/stream_byte_counter.sv | 36 +++
 rtl/stream_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bad_apple_pkg.sv
// Shared types and constants for the SD stream scheduler.
package bad_apple_pkg;

    localparam int         MODE_SWITCH_THRESHOLD = 64;
    localparam logic [7:0] HEADER_BYTE           = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        VIDEO = 2'd2,
        AUDIO = 2'd3
    } sched_state_t;

    // Terminal count for an N-byte run, as seen by a counter that starts at 0.
    function automatic logic [15:0] term_of(input int n);
        return 16'(n - 1);
    endfunction

endpackage

// File: rtl/stream_byte_counter.sv
// 16-bit byte counter with synchronous clear, count enable and terminal-count compare.
module stream_byte_counter
    import bad_apple_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [15:0] term_i,
    output logic        at_term_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // True while the byte about to be counted is the last one of the run.
    assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/stream_scheduler.sv
// Splits the SD byte stream into video/audio FIFO writes, one frame per header byte.
// Optional hunt timeout is built when STREAM_SCHED_TIMEOUT_EN is defined.
module stream_scheduler
    import bad_apple_pkg::*;
#(
    parameter int VIDEO_BYTES = 4800,
    parameter int AUDIO_BYTES = 735,
    parameter int HUNT_LIMIT  = 1024
) (
    input  logic        CLK_40,
    input  logic        reset_n,
    input  logic        init,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        vid_afull,
    input  logic        aud_afull,
    output logic        chip_select,
    output logic        spi_run,
    output logic        write_video,
    output logic        write_audio,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        sync_err
);

    localparam logic [15:0] VID_TERM = term_of(VIDEO_BYTES);
    localparam logic [15:0] AUD_TERM = term_of(AUDIO_BYTES);

    if (VIDEO_BYTES < 1 || AUDIO_BYTES < 1 || HUNT_LIMIT < 1) begin : g_param_err
        $error("stream_scheduler: byte counts must be at least 1");
    end

    sched_state_t state_q, state_d;
    logic         cs_q, cs_d;
    logic         spi_run_q, spi_run_d;
    logic         wr_vid_q, wr_vid_d;
    logic         wr_aud_q, wr_aud_d;
    logic [7:0]   wr_data_q, wr_data_d;
    logic         frame_done_q, frame_done_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;
    logic         overrun_q, overrun_d;
    logic         sync_err_q, sync_err_d;
    logic         slack_q, slack_d;

    logic         byte_in;
    logic         tgt_full;
    logic         drop;
    logic         cnt_clr;
    logic         frame_end;
    logic         byte_at_term;
    logic [15:0]  byte_term_val;
    logic         hunt_timeout;

    assign byte_in       = rx_valid && !init && (state_q == VIDEO || state_q == AUDIO);
    assign tgt_full      = (state_q == VIDEO && vid_afull) || (state_q == AUDIO && aud_afull);
    // One byte may land in the FIFO's slack entry; a second one while still full is lost.
    assign drop          = byte_in && tgt_full && slack_q;
    assign byte_term_val = (state_q == AUDIO) ? AUD_TERM : VID_TERM;
    assign frame_end     = byte_in && (state_q == AUDIO) && byte_at_term;
    assign cnt_clr       = init || (state_d != state_q);

    stream_byte_counter u_byte_cnt (
        .clk_i     (CLK_40),
        .rst_ni    (reset_n),
        .clear_i   (cnt_clr),
        .en_i      (byte_in),
        .term_i    (byte_term_val),
        .at_term_o (byte_at_term)
    );

`ifdef STREAM_SCHED_TIMEOUT_EN
    localparam logic [15:0] HUNT_TERM = term_of(HUNT_LIMIT);

    logic hunt_en;
    logic hunt_at_term;

    assign hunt_en = rx_valid && !init && (state_q == HUNT) && (rx_byte != HEADER_BYTE);

    stream_byte_counter u_hunt_cnt (
        .clk_i     (CLK_40),
        .rst_ni    (reset_n),
        .clear_i   (cnt_clr),
        .en_i      (hunt_en),
        .term_i    (HUNT_TERM),
        .at_term_o (hunt_at_term)
    );

    assign hunt_timeout = hunt_en && hunt_at_term;
`else
    assign hunt_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = HUNT;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                HUNT: begin
                    if (rx_valid && rx_byte == HEADER_BYTE) begin
                        state_d = VIDEO;
                    end else if (hunt_timeout) begin
                        state_d = IDLE;
                    end
                end
                VIDEO: begin
                    if (byte_in && byte_at_term) begin
                        state_d = AUDIO;
                    end
                end
                AUDIO: begin
                    if (frame_end) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cs_d         = (state_d == IDLE);
        // Pause the SPI master one cycle after the target FIFO reports almost full.
        spi_run_d    = (state_d != IDLE)
                       && !(state_d == VIDEO && vid_afull)
                       && !(state_d == AUDIO && aud_afull);
        wr_vid_d     = byte_in && !drop && (state_q == VIDEO);
        wr_aud_d     = byte_in && !drop && (state_q == AUDIO);
        wr_data_d    = wr_data_q;
        if (byte_in && !drop) begin
            wr_data_d = rx_byte;
        end
        frame_done_d = frame_end;
        frame_cnt_d  = frame_cnt_q + {15'd0, frame_end};
        overrun_d    = overrun_q || drop;
        sync_err_d   = hunt_timeout;
        slack_d      = slack_q;
        if (cnt_clr || !tgt_full) begin
            slack_d = 1'b0;
        end else if (byte_in) begin
            slack_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cs_q         <= 1'b1;
            spi_run_q    <= 1'b0;
            wr_vid_q     <= 1'b0;
            wr_aud_q     <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            slack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_q         <= cs_d;
            spi_run_q    <= spi_run_d;
            wr_vid_q     <= wr_vid_d;
            wr_aud_q     <= wr_aud_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            sync_err_q   <= sync_err_d;
            slack_q      <= slack_d;
        end
    end

    assign chip_select = cs_q;
    assign spi_run     = spi_run_q;
    assign write_video = wr_vid_q;
    assign write_audio = wr_aud_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign sync_err    = sync_err_q;

endmodule
